mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Two-port arbiter that shares the single Avalon-style memory bus (address/read/write/writedata/byteenable/waitrequest/readdata) between the CPU instruction-fetch port and the load/store data port. It sits between the fetch and memory stages of `mips_cpu_bus` and the external RAM. It serialises accesses, holds a grant for the whole transfer under downstream `waitrequest`, and keeps per-port grant counters and a sticky protocol-error flag for the testbench.

## Interface
- `D_PRIORITY`, 0: 0 = round-robin on ties; 1 = data port always wins ties.
- `CNT_W`, 16: width of the saturating grant counters.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_address` in 32, `i_read` in 1: instruction requester. Read-only.
- `i_waitrequest` out 1, `i_readdata` out 32: instruction responses.
- `d_address` in 32, `d_read` in 1, `d_write` in 1, `d_writedata` in 32, `d_byteenable` in 4: data requester.
- `d_waitrequest` out 1, `d_readdata` out 32: data responses.
- `address` out 32, `read` out 1, `write` out 1, `writedata` out 32, `byteenable` out 4: downstream memory bus.
- `waitrequest` in 1, `readdata` in 32: downstream responses.
- `i_grants` out CNT_W, `d_grants` out CNT_W: completed transfers per port.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- A port is requesting when `i_read`, or when `d_read|d_write`.
- A transfer completes in any granted cycle where `read|write` = 1 and `waitrequest` = 0. `readdata` is valid in that same cycle.
- FSM states are IDLE, GRANT_I and GRANT_D. A 1-bit `last` register records the most recently granted port.
- IDLE:
  - Only one port requesting: go to that port's grant state.
  - Both requesting with D_PRIORITY=1: go to GRANT_D.
  - Both requesting with D_PRIORITY=0: grant the port that is not `last`.
  - Neither requesting: stay in IDLE.
- GRANT_x:
  - The granted port's request fields drive the downstream bus combinationally.
  - Downstream `waitrequest` passes through to the granted port.
  - Downstream `readdata` passes through to both upstream readdata outputs.
  - On completion: increment that port's counter (saturating at all-ones) and set `last` = x.
  - After completion, go to the other grant state if the other port is requesting, otherwise to IDLE.
- The ungranted port always sees waitrequest = 1.
- In IDLE the downstream `read`/`write` are 0, and both upstream waitrequests are 1.
- If the granted port drops its request before completion: set `proto_err`, go to IDLE, and do not increment the counter.
- If `d_read` and `d_write` are both 1 while granted: set `proto_err`, and forward only `write`.
- Address, writedata and byteenable are passed through unchanged. There are no width conversions.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, `last` = I (so the first tie in round-robin goes to D).
  - Counters = 0, `proto_err` = 0.
  - `read`/`write` = 0, `address`/`writedata` = 0, `byteenable` = 0.
  - Both upstream waitrequests = 1.
- Arbitration latency from IDLE is one cycle. A request first seen in cycle N is driven downstream in cycle N+1, and completes no earlier than N+1.
- Handover between ports costs zero idle cycles when the other port is already requesting at completion.
- The same port reissuing after its own completion passes through IDLE, a one-cycle bubble.
- A grant is never pre-empted while `waitrequest` = 1, regardless of the other port's requests.
- Reset asserted mid-transfer drops the bus to idle values immediately. No partial completion is counted.

## Structure
- Shared package `mips_bus_pkg` holds:
  - the state enum `arb_state_t` (IDLE, GRANT_I, GRANT_D);
  - the port-select enum (PORT_I, PORT_D);
  - the bus width constants ADDR_W=32, DATA_W=32, BE_W=4.
- One natural sub-module: `sat_counter` (parameter CNT_W; ports: increment enable, value out), instantiated once per port.
- Muxing and the FSM stay in the top module.

## Test plan
- **Single fetch.**
  - Stimulus: `i_read`=1, `i_address`=0xBFC00000, memory returns 0x8C020004 with `waitrequest`=0.
  - Required: `i_waitrequest`=0 in cycle 2; `i_readdata`=0x8C020004; `i_grants`=1.
- **Tie with D_PRIORITY=0, both ports requesting from reset.**
  - Order must be D, then I, then D; `last` must alternate.
- **Tie with D_PRIORITY=1.**
  - Stimulus: `d_write` held to 0x00000010 with `d_byteenable`=0b0011, and `i_read` held.
  - Required: D is served every time it requests; I is served only when D is idle.
- **Downstream wait states.**
  - Stimulus: `waitrequest`=1 for 3 cycles during a D write, with I requesting throughout.
  - Required: the grant stays on D; I sees waitrequest=1; I is granted in the cycle after D completes.
- **Protocol error and reset.**
  - Stimulus: the granted I port drops `i_read` mid-wait.
  - Required: `proto_err`=1, state returns to IDLE, `i_grants` unchanged.
  - Then assert `reset_n`=0 asynchronously. Required: all outputs return to their reset values without waiting for a clock edge.
- **Saturation.**
  - Stimulus: CNT_W=4, 20 back-to-back I fetches.
  - Required: `i_grants` stops at 15.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared types and bus widths for the MIPS memory-bus arbiter.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] value_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory bus between the instruction-fetch and load/store ports.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int D_PRIORITY = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_writedata,
  input  logic [BE_W-1:0]   d_byteenable,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  output logic [DATA_W-1:0] writedata,
  output logic [BE_W-1:0]   byteenable,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants,
  output logic              proto_err
);

  arb_state_t state_q, state_d;
  port_t      last_q, last_d;
  logic       proto_err_q, proto_err_d;
  logic       i_req, d_req, i_done, d_done;

  assign i_req  = i_read;
  assign d_req  = d_read | d_write;
  assign i_done = (state_q == GRANT_I) && i_req && !waitrequest;
  assign d_done = (state_q == GRANT_D) && d_req && !waitrequest;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = '0;
    byteenable    = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    case (state_q)
      GRANT_I: begin
        address       = i_address;
        read          = i_read;
        i_waitrequest = waitrequest;
      end
      GRANT_D: begin
        address       = d_address;
        write         = d_write;
        read          = d_read & ~d_write;  // a read+write collision forwards only the write
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
      end
      default: ;
    endcase
  end

  assign i_readdata = readdata;
  assign d_readdata = readdata;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    proto_err_d = proto_err_q;
    case (state_q)
      IDLE: begin
        if (i_req && d_req) begin
          state_d = ((D_PRIORITY != 0) || (last_q == PORT_I)) ? GRANT_D : GRANT_I;
        end else if (i_req) begin
          state_d = GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        if (!i_req) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (!waitrequest) begin
          last_d  = PORT_I;
          state_d = d_req ? GRANT_D : IDLE;
        end
      end
      GRANT_D: begin
        if (!d_req) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if (d_read && d_write) proto_err_d = 1'b1;
          if (!waitrequest) begin
            last_d  = PORT_D;
            state_d = i_req ? GRANT_I : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset leaves last = I so the first round-robin tie goes to the data port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      last_q      <= PORT_I;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (i_done),
    .value_o (i_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (d_done),
    .value_o (d_grants)
  );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Scoreboard bench for mips_bus_arbiter: round-robin instance (dut0) and data-priority instance (dut1).
module tb_mips_bus_arbiter;
  import mips_bus_pkg::*;

  typedef struct packed {
    port_t       port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // dut0: D_PRIORITY=0, CNT_W=4
  logic [31:0] i_address, d_address, d_writedata, readdata;
  logic        i_read, d_read, d_write, waitrequest;
  logic [3:0]  d_byteenable;
  logic        i_waitrequest, d_waitrequest, read, write, proto_err;
  logic [31:0] i_readdata, d_readdata, address, writedata;
  logic [3:0]  byteenable, i_grants, d_grants;

  // dut1: D_PRIORITY=1, CNT_W=4
  logic [31:0] p_i_address, p_d_address, p_d_writedata, p_readdata;
  logic        p_i_read, p_d_read, p_d_write, p_waitrequest;
  logic [3:0]  p_d_byteenable;
  logic        p_i_waitrequest, p_d_waitrequest, p_read, p_write, p_proto_err;
  logic [31:0] p_i_readdata, p_d_readdata, p_address, p_writedata;
  logic [3:0]  p_byteenable, p_i_grants, p_d_grants;

  mips_bus_arbiter #(.D_PRIORITY(0), .CNT_W(4)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .i_address(i_address), .i_read(i_read),
    .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .i_grants(i_grants), .d_grants(d_grants), .proto_err(proto_err)
  );

  mips_bus_arbiter #(.D_PRIORITY(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .i_address(p_i_address), .i_read(p_i_read),
    .i_waitrequest(p_i_waitrequest), .i_readdata(p_i_readdata),
    .d_address(p_d_address), .d_read(p_d_read), .d_write(p_d_write),
    .d_writedata(p_d_writedata), .d_byteenable(p_d_byteenable),
    .d_waitrequest(p_d_waitrequest), .d_readdata(p_d_readdata),
    .address(p_address), .read(p_read), .write(p_write),
    .writedata(p_writedata), .byteenable(p_byteenable),
    .waitrequest(p_waitrequest), .readdata(p_readdata),
    .i_grants(p_i_grants), .d_grants(p_d_grants), .proto_err(p_proto_err)
  );

  int    checks = 0;
  int    errors = 0;
  xfer_t q0[$];
  xfer_t q1[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input port_t p, input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
    xfer_t x;
    x.port = p;
    x.wr   = wr;
    x.addr = a;
    x.data = d;
    return x;
  endfunction

  task automatic mon(input int id, input logic i_w, input logic d_w, input logic [31:0] addr,
                     input logic wr, input logic [31:0] wdata, input logic [31:0] i_rd,
                     input logic [31:0] d_rd);
    xfer_t act, exp;
    act.port = i_w ? PORT_D : PORT_I;
    act.wr   = wr;
    act.addr = addr;
    act.data = wr ? wdata : (i_w ? d_rd : i_rd);
    check($sformatf("grant_onehot%0d", id), {127'd0, i_w ^ d_w}, 128'd1);
    if (((id == 0) ? q0.size() : q1.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_xfer%0d: got %0h expected none", id, act);
    end else begin
      exp = (id == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("xfer%0d", id), {62'd0, act}, {62'd0, exp});
    end
  endtask

  always @(negedge clk)
    if (reset_n && (read || write) && !waitrequest)
      mon(0, i_waitrequest, d_waitrequest, address, write, writedata, i_readdata, d_readdata);

  always @(negedge clk)
    if (reset_n && (p_read || p_write) && !p_waitrequest)
      mon(1, p_i_waitrequest, p_d_waitrequest, p_address, p_write, p_writedata,
          p_i_readdata, p_d_readdata);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_address = '0; i_read = 0; d_address = '0; d_read = 0; d_write = 0;
    d_writedata = '0; d_byteenable = '0; waitrequest = 0; readdata = '0;
    p_i_address = '0; p_i_read = 0; p_d_address = '0; p_d_read = 0; p_d_write = 0;
    p_d_writedata = '0; p_d_byteenable = '0; p_waitrequest = 0; p_readdata = '0;

    // Reset values
    #12;
    check("rst_i_wait", i_waitrequest, 1);
    check("rst_d_wait", d_waitrequest, 1);
    check("rst_rw", {read, write}, 0);
    check("rst_addr", address, 0);
    check("rst_be", byteenable, 0);
    check("rst_cnt", {i_grants, d_grants}, 0);
    check("rst_perr", proto_err, 0);
    tick();
    reset_n = 1'b1;

    // Data-priority tie (dut1): D, then D wins a tie from IDLE even though last = D
    p_d_write = 1; p_d_address = 32'h10; p_d_writedata = 32'h10; p_d_byteenable = 4'b0011;
    p_readdata = 32'h1234_5678;
    q1.push_back(mk(PORT_D, 1'b1, 32'h10, 32'h10));
    q1.push_back(mk(PORT_D, 1'b1, 32'h10, 32'h10));
    q1.push_back(mk(PORT_I, 1'b0, 32'h500, 32'h1234_5678));
    q1.push_back(mk(PORT_D, 1'b1, 32'h10, 32'h10));
    @(negedge clk) check("prio_idle_wait", p_d_waitrequest, 1);
    tick();
    @(negedge clk) check("prio_be", {p_write, p_byteenable}, 5'b1_0011);
    tick();
    p_i_read = 1; p_i_address = 32'h500;
    tick();
    @(negedge clk) check("prio_d_wins", {p_i_waitrequest, p_d_waitrequest}, 2'b10);
    tick();
    tick();
    p_i_read = 0;
    tick();
    p_d_write = 0;
    tick();
    check("prio_cnt", {p_i_grants, p_d_grants}, {4'd1, 4'd3});

    // Single fetch
    i_read = 1; i_address = 32'hBFC0_0000; readdata = 32'h8C02_0004; waitrequest = 0;
    q0.push_back(mk(PORT_I, 1'b0, 32'hBFC0_0000, 32'h8C02_0004));
    @(negedge clk) check("fetch_c1_wait", i_waitrequest, 1);
    @(negedge clk) begin
      check("fetch_c2_wait", i_waitrequest, 0);
      check("fetch_rdata", i_readdata, 32'h8C02_0004);
    end
    tick();
    i_read = 0;
    @(negedge clk) check("fetch_cnt", i_grants, 1);

    // Round-robin tie from reset: D, I, D
    do_reset();
    i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200; readdata = 32'hCAFE_F00D;
    q0.push_back(mk(PORT_D, 1'b0, 32'h200, 32'hCAFE_F00D));
    q0.push_back(mk(PORT_I, 1'b0, 32'h100, 32'hCAFE_F00D));
    q0.push_back(mk(PORT_D, 1'b0, 32'h200, 32'hCAFE_F00D));
    @(negedge clk) check("rr_idle_wait", {i_waitrequest, d_waitrequest}, 2'b11);
    tick();
    tick();
    tick();
    i_read = 0;
    tick();
    d_read = 0;
    @(negedge clk) check("rr_cnt", {i_grants, d_grants}, {4'd1, 4'd2});

    // Downstream wait states on a D write with I requesting throughout
    do_reset();
    d_write = 1; d_address = 32'h10; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'hF;
    i_read = 1; i_address = 32'h300; waitrequest = 1; readdata = 32'h0BAD_C0DE;
    q0.push_back(mk(PORT_D, 1'b1, 32'h10, 32'hDEAD_BEEF));
    q0.push_back(mk(PORT_I, 1'b0, 32'h300, 32'h0BAD_C0DE));
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk) begin
        check($sformatf("ws%0d_write", k), write, 1);
        check($sformatf("ws%0d_addr", k), address, 32'h10);
        check($sformatf("ws%0d_waits", k), {i_waitrequest, d_waitrequest}, 2'b11);
      end
      tick();
    end
    waitrequest = 0;
    tick();
    d_write = 0;
    @(negedge clk) check("ws_i_next", i_waitrequest, 0);
    tick();
    i_read = 0;
    @(negedge clk) check("ws_cnt", {i_grants, d_grants}, {4'd1, 4'd1});

    // Protocol error: granted I drops its request mid-wait
    check("perr_clear", proto_err, 0);
    i_read = 1; i_address = 32'h400; waitrequest = 1;
    tick();
    @(negedge clk) check("perr_granted", read, 1);
    tick();
    i_read = 0;
    tick();
    @(negedge clk) begin
      check("perr_set", proto_err, 1);
      check("perr_idle", {read, i_waitrequest, d_waitrequest}, 3'b011);
      check("perr_cnt", i_grants, 1);
    end
    tick();
    i_read = 1;
    tick();
    @(negedge clk) check("pre_rst_addr", {read, address}, {1'b1, 32'h400});
    #2 reset_n = 1'b0;
    #1 begin
      check("arst_bus", {read, write, address}, 0);
      check("arst_waits", {i_waitrequest, d_waitrequest}, 2'b11);
      check("arst_state", {proto_err, i_grants, d_grants}, 0);
    end
    i_read = 0; waitrequest = 0;
    tick();
    reset_n = 1'b1;

    // Saturation: 20 back-to-back fetches into a 4-bit counter
    i_read = 1; i_address = 32'h600; readdata = 32'h1111_1111;
    for (int n = 0; n < 20; n++) q0.push_back(mk(PORT_I, 1'b0, 32'h600, 32'h1111_1111));
    repeat (16) tick();
    @(negedge clk) check("sat_mid", i_grants, 8);
    repeat (24) tick();
    i_read = 0;
    @(negedge clk) begin
      check("sat_end", i_grants, 15);
      check("sat_perr", proto_err, 0);
    end

    tick();
    check("q0_empty", q0.size(), 0);
    check("q1_empty", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
